pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_pkg.sv | 22 ++
 rtl/sync_ff.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 123 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_pkg.sv
// Shared state codes, parameter defaults and sizing helper for the PLL reset sequencer.
package pll_reset_pkg;

  // FSM state codes, also visible on the state output.
  localparam logic [1:0] ST_WAIT_LOCK  = 2'd0;
  localparam logic [1:0] ST_STABILIZE  = 2'd1;
  localparam logic [1:0] ST_HOLD_RESET = 2'd2;
  localparam logic [1:0] ST_RUN        = 2'd3;

  localparam int unsigned DEF_SYNC_STAGES        = 2;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_RESET_HOLD_CYCLES  = 16;
  localparam int unsigned DEF_LOSS_CNT_WIDTH     = 8;

  // Width of a counter that must reach max(a, b) - 1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the input through the chain; reset clears every stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds downstream logic in reset until the PLL lock has been stable for a while,
// then releases it; re-enters reset on lock loss or a soft reset request.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int unsigned LOSS_CNT_WIDTH     = DEF_LOSS_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pll_lock,
  input  logic                      soft_reset_req,
  output logic                      sys_rst,
  output logic                      ready,
  output logic [1:0]                state,
  output logic [LOSS_CNT_WIDTH-1:0] lock_loss_count
);

  localparam int unsigned CNT_W = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
  // Last counter value of each timed state; the transition fires on that cycle.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

  logic                      lock_sync;
  logic [1:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [LOSS_CNT_WIDTH-1:0] loss_q, loss_d;
  logic                      sys_rst_q, sys_rst_d;
  logic                      ready_q, ready_d;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (pll_lock),
    .q_o   (lock_sync)
  );

  // Next-state, shared counter and lock-loss counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_sync) begin
          state_d = ST_STABILIZE;
        end
      end
      ST_STABILIZE: begin
        if (!lock_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HOLD_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD_RESET: begin
        if (!lock_sync) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        // Lock loss takes priority over a simultaneous soft reset request.
        if (!lock_sync) begin
          state_d = ST_WAIT_LOCK;
          if (loss_q != '1) begin
            loss_d = loss_q + LOSS_CNT_WIDTH'(1);
          end
        end else if (soft_reset_req) begin
          state_d = ST_HOLD_RESET;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the next state so they switch on the same edge as the state.
  always_comb begin
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      loss_q    <= '0;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      loss_q    <= loss_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
    end
  end

  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

  localparam int unsigned SS    = 2;
  localparam int unsigned LSC   = 8;
  localparam int unsigned RHC   = 4;
  localparam int unsigned LW    = 2;
  localparam int unsigned TOTAL = SS + 1 + LSC + RHC;  // 15 edges

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_lock = 1'b0;
  logic          soft_reset_req = 1'b0;
  logic          sys_rst;
  logic          ready;
  logic [1:0]    state;
  logic [LW-1:0] lock_loss_count;

  int vectors     = 0;
  int miscompares = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES        (SS),
    .LOCK_STABLE_CYCLES (LSC),
    .RESET_HOLD_CYCLES  (RHC),
    .LOSS_CNT_WIDTH     (LW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_lock        (pll_lock),
    .soft_reset_req  (soft_reset_req),
    .sys_rst         (sys_rst),
    .ready           (ready),
    .state           (state),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected state k edges after the first edge sampling pll_lock=1.
  function automatic logic [1:0] seq_state(input int k);
    if (k <= int'(SS)) return 2'd0;
    else if (k <= int'(SS + LSC)) return 2'd1;
    else if (k < int'(TOTAL)) return 2'd2;
    else return 2'd3;
  endfunction

  // Raise pll_lock and follow the full release sequence edge by edge.
  // A soft reset pulse is injected on edge soft_at (0 = none); it must be ignored.
  task automatic lock_sequence(input string name, input logic [LW-1:0] exp_cnt,
                               input int soft_at);
    logic [1:0] st;
    logic [5:0] got, want;
    pll_lock = 1'b1;
    for (int k = 1; k <= int'(TOTAL); k++) begin
      soft_reset_req = (k == soft_at);
      tick();
      soft_reset_req = 1'b0;
      st   = seq_state(k);
      want = {(st != 2'd3), (st == 2'd3), st, exp_cnt};
      got  = {sys_rst, ready, state, lock_loss_count};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s edge %0d: {sys_rst,ready,state,count}=%b required %b",
                 name, k, got, want);
      end
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b1;
    pll_lock = 1'b0;
    tick();
    tick();
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b10_00_00) begin
      miscompares++;
      $display("FAIL reset_values: got %b required %b", got, 6'b10_00_00);
    end
    rst = 1'b0;
    tick();
    tick();
    tick();
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b10_00_00) begin
      miscompares++;
      $display("FAIL idle_no_lock: got %b required %b", got, 6'b10_00_00);
    end
  endtask

  task automatic test_release();
    lock_sequence("release", 2'd0, 0);
  endtask

  task automatic test_abort();
    logic [5:0] got;
    rst = 1'b1;
    pll_lock = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    pll_lock = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b10_01_00) begin
      miscompares++;
      $display("FAIL abort_in_stab: got %b required %b", got, 6'b10_01_00);
    end
    pll_lock = 1'b0;
    tick();
    tick();
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b10_01_00) begin
      miscompares++;
      $display("FAIL abort_sync_delay: got %b required %b", got, 6'b10_01_00);
    end
    tick();
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b10_00_00) begin
      miscompares++;
      $display("FAIL abort_to_wait: got %b required %b", got, 6'b10_00_00);
    end
    lock_sequence("abort_relock", 2'd0, 0);
  endtask

  task automatic test_loss_count();
    logic [5:0]    got, want;
    logic [LW-1:0] prev, cur;
    for (int i = 1; i <= 4; i++) begin
      prev = LW'((i - 1 > 3) ? 3 : i - 1);
      cur  = LW'((i > 3) ? 3 : i);
      pll_lock = 1'b0;
      tick();
      tick();
      want = {2'b01, 2'd3, prev};
      got  = {sys_rst, ready, state, lock_loss_count};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL loss%0d_edge2: got %b required %b", i, got, want);
      end
      tick();
      want = {2'b10, 2'd0, cur};
      got  = {sys_rst, ready, state, lock_loss_count};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL loss%0d_edge3: got %b required %b", i, got, want);
      end
      lock_sequence("loss_relock", cur, 0);
    end
  endtask

  task automatic test_soft_reset();
    logic [5:0] got, want;
    soft_reset_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      soft_reset_req = 1'b0;
      want = (k < 5) ? {2'b10, 2'd2, 2'd3} : {2'b01, 2'd3, 2'd3};
      got  = {sys_rst, ready, state, lock_loss_count};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL soft_run edge %0d: got %b required %b", k, got, want);
      end
    end
    // Count is saturated, so this drop leaves it at 3.
    pll_lock = 1'b0;
    tick();
    tick();
    tick();
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b10_00_11) begin
      miscompares++;
      $display("FAIL soft_pre_stab: got %b required %b", got, 6'b10_00_11);
    end
    lock_sequence("soft_in_stab", 2'd3, 5);
  endtask

  task automatic test_simultaneous();
    logic [5:0] got;
    rst = 1'b1;
    pll_lock = 1'b0;
    tick();
    rst = 1'b0;
    lock_sequence("sim_release", 2'd0, 0);
    pll_lock = 1'b0;
    tick();
    tick();
    soft_reset_req = 1'b1;  // sampled on the same edge lock_sync is first 0
    tick();
    soft_reset_req = 1'b0;
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b10_00_01) begin
      miscompares++;
      $display("FAIL sim_loss_wins: got %b required %b", got, 6'b10_00_01);
    end
    lock_sequence("sim_relock", 2'd1, 0);
  endtask

  task automatic test_async_reset();
    logic [5:0] got;
    pll_lock = 1'b0;
    tick();
    tick();
    tick();
    pll_lock = 1'b1;
    for (int k = 1; k <= 12; k++) tick();
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b10_10_10) begin
      miscompares++;
      $display("FAIL pre_rst_hold: got %b required %b", got, 6'b10_10_10);
    end
    rst = 1'b1;
    #1;
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b10_00_00) begin
      miscompares++;
      $display("FAIL rst_in_hold: got %b required %b", got, 6'b10_00_00);
    end
    tick();
    tick();
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b10_00_00) begin
      miscompares++;
      $display("FAIL rst_held: got %b required %b", got, 6'b10_00_00);
    end
    rst = 1'b0;
    lock_sequence("post_rst_hold", 2'd0, 0);
    pll_lock = 1'b0;
    tick();
    tick();
    tick();
    lock_sequence("pre_rst_run", 2'd1, 0);
    tick();
    tick();
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b01_11_01) begin
      miscompares++;
      $display("FAIL pre_rst_run: got %b required %b", got, 6'b01_11_01);
    end
    rst = 1'b1;
    #1;
    got = {sys_rst, ready, state, lock_loss_count};
    vectors++;
    if (got !== 6'b10_00_00) begin
      miscompares++;
      $display("FAIL rst_in_run: got %b required %b", got, 6'b10_00_00);
    end
    tick();
    rst = 1'b0;
    lock_sequence("post_rst_run", 2'd0, 0);
  endtask

  initial begin
    test_reset();
    test_release();
    test_abort();
    test_loss_count();
    test_soft_reset();
    test_simultaneous();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
